// File: rtl/apb_gpio_v2_pkg.sv
// apb_gpio_pkg: shared constants for the APB GPIO block.
//   APB_AW        - APB byte-address width
//   OFF_*         - register byte offsets
//   word_addr()   - strips the byte-lane bits [1:0] from an address
package apb_gpio_pkg;

    localparam int APB_AW = 8;

    localparam logic [APB_AW-1:0] OFF_OUT     = 8'h00;
    localparam logic [APB_AW-1:0] OFF_DIR     = 8'h04;
    localparam logic [APB_AW-1:0] OFF_IN      = 8'h08;
    localparam logic [APB_AW-1:0] OFF_SET     = 8'h0C;
    localparam logic [APB_AW-1:0] OFF_CLR     = 8'h10;
    localparam logic [APB_AW-1:0] OFF_RISE_EN = 8'h14;
    localparam logic [APB_AW-1:0] OFF_FALL_EN = 8'h18;
    localparam logic [APB_AW-1:0] OFF_STATUS  = 8'h1C;
    // Highest mapped offset; anything above it is an error response.
    localparam logic [APB_AW-1:0] OFF_LAST    = OFF_STATUS;

    function automatic logic [APB_AW-1:0] word_addr(input logic [APB_AW-1:0] a);
        return {a[APB_AW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/apb_gpio_v2_if.sv
// apb_gpio_v2_if: APB3 completer-side bus bundle.
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA - requester to completer
//   PRDATA, PREADY, PSLVERR              - completer to requester
// Modports: master (bus requester / testbench), slave (GPIO block).
interface apb_gpio_v2_if;
    import apb_gpio_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic [APB_AW-1:0] PADDR;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_gpio_v2_sync.sv
// gpio_sync: multi-flop synchroniser for asynchronous pin inputs.
//   clk, rst - clock, synchronous active-high reset
//   d        - asynchronous input bus (WIDTH bits)
//   q        - synchronised output, DEPTH cycles behind d
module gpio_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/apb_gpio_v2.sv
// apb_gpio_v2: APB3 GPIO block with optional edge-interrupt logic.
//   PCLK, PRESET - clock, synchronous active-high reset
//   apb          - APB completer bus (zero wait states)
//   gpio_i       - asynchronous pin inputs
//   gpio_o       - pin output values (OUT register)
//   gpio_oe      - per-pin output enable (DIR register, 1 = drive)
//   irq          - level interrupt, present only with GPIO_IRQ_EN
// Build option: define GPIO_IRQ_EN to add RISE_EN/FALL_EN/STATUS, edge
// detection and the irq port. Without it 0x14..0x1C read 0 and ignore writes.
module apb_gpio_v2
    import apb_gpio_pkg::*;
#(
    parameter int GPIO_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_gpio_v2_if.slave      apb,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe
`ifdef GPIO_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic              access, wr, rd, unmapped;
    logic [APB_AW-1:0] addr;
    logic [GPIO_W-1:0] wdata;
    logic [GPIO_W-1:0] out_q, dir_q, sync_q;
    logic [31:0]       rdata;

    assign access   = apb.PSEL & apb.PENABLE;
    assign wr       = access &  apb.PWRITE;
    assign rd       = access & ~apb.PWRITE;
    assign addr     = word_addr(apb.PADDR);
    assign unmapped = (addr > OFF_LAST);
    assign wdata    = apb.PWDATA[GPIO_W-1:0];

    // Byte-lane address bits and PWDATA above the pin count are ignored.
    logic unused_addr;
    assign unused_addr = ^apb.PADDR[1:0];
    if (GPIO_W < 32) begin : g_unused_wdata
        logic unused_hi;
        assign unused_hi = ^apb.PWDATA[31:GPIO_W];
    end

    gpio_sync #(
        .WIDTH (GPIO_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk (PCLK),
        .rst (PRESET),
        .d   (gpio_i),
        .q   (sync_q)
    );

    // OUT / DIR / SET / CLR. Unmapped addresses match no case item, so an
    // errored write leaves every register untouched.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (wr) begin
            case (addr)
                OFF_OUT: out_q <= wdata;
                OFF_DIR: dir_q <= wdata;
                OFF_SET: out_q <= out_q | wdata;
                OFF_CLR: out_q <= out_q & ~wdata;
                default: ;
            endcase
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;

`ifdef GPIO_IRQ_EN
    logic [GPIO_W-1:0] prev_q, rise_en_q, fall_en_q, status_q;
    logic [GPIO_W-1:0] evt, w1c, status_nxt;
    logic              irq_q;

    // prev resets with the synchroniser, so no spurious edge after reset.
    assign evt        = ( sync_q & ~prev_q & rise_en_q) |
                        (~sync_q &  prev_q & fall_en_q);
    assign w1c        = (wr && addr == OFF_STATUS) ? wdata : '0;
    // Clear first, then OR events: a same-cycle edge beats the W1C.
    assign status_nxt = (status_q & ~w1c) | evt;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prev_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            prev_q   <= sync_q;
            status_q <= status_nxt;
            irq_q    <= |status_q;
            if (wr && addr == OFF_RISE_EN) rise_en_q <= wdata;
            if (wr && addr == OFF_FALL_EN) fall_en_q <= wdata;
        end
    end

    assign irq = irq_q;
`endif

    // Read mux; WO and (in the reduced build) absent registers read 0.
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                OFF_OUT:     rdata = 32'(out_q);
                OFF_DIR:     rdata = 32'(dir_q);
                OFF_IN:      rdata = 32'(sync_q);
`ifdef GPIO_IRQ_EN
                OFF_RISE_EN: rdata = 32'(rise_en_q);
                OFF_FALL_EN: rdata = 32'(fall_en_q);
                OFF_STATUS:  rdata = 32'(status_q);
`endif
                default:     rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = access;
    assign apb.PSLVERR = access & unmapped;

endmodule

// File: tb/tb_apb_gpio_v2.sv
// tb_apb_gpio_v2: directed self-checking bench for apb_gpio_v2
// (GPIO_W = 8, SYNC_STAGES = 2). Covers the irq logic when GPIO_IRQ_EN
// is defined, otherwise the reduced register map.
module tb_apb_gpio_v2;

    logic       PCLK;
    logic       PRESET;
    logic [7:0] gpio_i, gpio_o, gpio_oe;
`ifdef GPIO_IRQ_EN
    logic       irq;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    apb_gpio_v2_if bus ();

    apb_gpio_v2 #(
        .GPIO_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .apb     (bus),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe)
`ifdef GPIO_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Setup on a falling edge, access on the next; returns at the falling
    // edge after the commit edge.
    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = a;   bus.PWDATA = d;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1 err = bus.PSLVERR;
        @(negedge PCLK);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d,
                          output logic err, output logic rdy);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1 d = bus.PRDATA; err = bus.PSLVERR; rdy = bus.PREADY;
        @(negedge PCLK);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e, r;

        PRESET = 1'b1; gpio_i = 8'h00;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 8'h00; bus.PWDATA = 32'h0;
        repeat (2) @(negedge PCLK);
        // A write committed while reset is held must be lost.
        apb_wr(8'h00, 32'hFF, e);
        PRESET = 1'b0;
        #1;
        chk("rst_gpio_o",  32'(gpio_o),  32'h0);
        chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        chk("rst_prdata",  bus.PRDATA,   32'h0);
        chk("rst_pready",  32'(bus.PREADY),  32'h0);
        chk("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
`ifdef GPIO_IRQ_EN
        chk("rst_irq", 32'(irq), 32'h0);
`endif

        // OUT / DIR write and readback
        apb_wr(8'h00, 32'hA5, e);
        chk("out_gpio_o", 32'(gpio_o), 32'hA5);
        apb_wr(8'h04, 32'h0F, e);
        chk("dir_gpio_oe", 32'(gpio_oe), 32'h0F);
        apb_rd(8'h00, d, e, r);
        chk("rd_out",    d, 32'h0000_00A5);
        chk("rd_pready", 32'(r), 32'h1);
        chk("rd_err",    32'(e), 32'h0);
        apb_rd(8'h04, d, e, r);
        chk("rd_dir", d, 32'h0F);

        // SET / CLR
        apb_wr(8'h0C, 32'h02, e);
        chk("set_gpio_o", 32'(gpio_o), 32'hA7);
        apb_wr(8'h10, 32'h80, e);
        chk("clr_gpio_o", 32'(gpio_o), 32'h27);
        apb_rd(8'h0C, d, e, r);
        chk("rd_set_wo", d, 32'h0);
        apb_rd(8'h10, d, e, r);
        chk("rd_clr_wo", d, 32'h0);

        // High PWDATA bits ignored; PADDR[1:0] ignored
        apb_wr(8'h00, 32'hFFFF_FF3C, e);
        chk("wide_gpio_o", 32'(gpio_o), 32'h3C);
        apb_rd(8'h01, d, e, r);
        chk("rd_out_unaligned", d, 32'h0000_003C);

        // Synchroniser latency: held read of IN
        @(negedge PCLK);
        gpio_i = 8'h09;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 8'h08;
        #1 chk("in_lat0", bus.PRDATA, 32'h00);
        @(negedge PCLK);
        #1 chk("in_lat1", bus.PRDATA, 32'h00);
        @(negedge PCLK);
        #1 chk("in_lat2", bus.PRDATA, 32'h09);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;

        // Unmapped address
        apb_rd(8'h40, d, e, r);
        chk("bad_rd_err",   32'(e), 32'h1);
        chk("bad_rd_data",  d,      32'h0);
        chk("bad_rd_ready", 32'(r), 32'h1);
        apb_wr(8'h40, 32'hFF, e);
        chk("bad_wr_err", 32'(e), 32'h1);
        chk("bad_wr_out", 32'(gpio_o),  32'h3C);
        chk("bad_wr_dir", 32'(gpio_oe), 32'h0F);
        apb_rd(8'h1C, d, e, r);
        chk("status_addr_err", 32'(e), 32'h0);

`ifdef GPIO_IRQ_EN
        apb_wr(8'h14, 32'h01, e);
        apb_rd(8'h14, d, e, r);
        chk("rd_rise_en", d, 32'h01);
        apb_rd(8'h1C, d, e, r);
        chk("status_idle", d, 32'h00);

        // Rising edge on bit 0 -> STATUS, then irq
        gpio_i = 8'h00;
        repeat (4) @(negedge PCLK);
        gpio_i = 8'h01;
        repeat (4) @(negedge PCLK);
        chk("irq_set", 32'(irq), 32'h1);
        apb_rd(8'h1C, d, e, r);
        chk("status_rise", d, 32'h01);
        apb_wr(8'h1C, 32'h01, e);
        chk("irq_hold", 32'(irq), 32'h1);
        @(negedge PCLK);
        chk("irq_clr", 32'(irq), 32'h0);
        apb_rd(8'h1C, d, e, r);
        chk("status_w1c", d, 32'h00);

        // Edge event in the same cycle as the W1C of that bit
        gpio_i = 8'h00;
        repeat (4) @(negedge PCLK);
        gpio_i = 8'h01;
        apb_wr(8'h1C, 32'h01, e);
        apb_rd(8'h1C, d, e, r);
        chk("status_set_wins", d, 32'h01);
        chk("irq_set_wins", 32'(irq), 32'h1);

        // Falling edge on bit 3
        gpio_i = 8'h08;
        repeat (4) @(negedge PCLK);
        apb_wr(8'h18, 32'h08, e);
        apb_wr(8'h1C, 32'hFF, e);
        apb_rd(8'h1C, d, e, r);
        chk("status_pre_fall", d, 32'h00);
        apb_rd(8'h18, d, e, r);
        chk("rd_fall_en", d, 32'h08);
        gpio_i = 8'h00;
        repeat (4) @(negedge PCLK);
        apb_rd(8'h1C, d, e, r);
        chk("status_fall", d, 32'h08);
`else
        apb_wr(8'h14, 32'hFF, e);
        chk("noirq_wr_err", 32'(e), 32'h0);
        apb_rd(8'h14, d, e, r);
        chk("noirq_rd_rise", d, 32'h0);
        chk("noirq_rd_err", 32'(e), 32'h0);
        apb_wr(8'h1C, 32'hFF, e);
        apb_rd(8'h1C, d, e, r);
        chk("noirq_rd_status", d, 32'h0);
        chk("noirq_out_kept", 32'(gpio_o), 32'h3C);
`endif

        // Mid-run reset clears the registers
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst2_gpio_o",  32'(gpio_o),  32'h0);
        chk("rst2_gpio_oe", 32'(gpio_oe), 32'h0);
`ifdef GPIO_IRQ_EN
        @(negedge PCLK);
        chk("rst2_irq", 32'(irq), 32'h0);
        apb_rd(8'h1C, d, e, r);
        chk("rst2_status", d, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_gpio_v2.md
APB_GPIO_V2 -- requirements
Module: apb_gpio_v2

Interface
REQ-001 SHALL have parameter GPIO_W, default 8, pin count (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal range 2..3).
REQ-003 SHALL have port PCLK, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port PRESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have port PSEL, input, 1, APB select.
REQ-006 SHALL have port PENABLE, input, 1, APB access phase.
REQ-007 SHALL have port PADDR, input, 8, byte address; bits [1:0] ignored.
REQ-008 SHALL have port PWRITE, input, 1, 1 = write.
REQ-009 SHALL have port PWDATA, input, 32, write data.
REQ-010 SHALL have port PRDATA, output, 32, read data.
REQ-011 SHALL have port PREADY, output, 1, transfer complete.
REQ-012 SHALL have port PSLVERR, output, 1, unmapped-address error.
REQ-013 SHALL have port gpio_i, input, GPIO_W, asynchronous pin inputs.
REQ-014 SHALL have port gpio_o, output, GPIO_W, pin output values.
REQ-015 SHALL have port gpio_oe, output, GPIO_W, per-pin output enable (1 = drive).
REQ-016 SHALL have port irq, output, 1, level interrupt (exists only with GPIO_IRQ_EN).

Function
REQ-017 SHALL decode the register map: 0x00 OUT (RW), 0x04 DIR (RW), 0x08 IN (RO), 0x0C SET (WO, OR into OUT), 0x10 CLR (WO, AND-NOT into OUT), 0x14 RISE_EN (RW), 0x18 FALL_EN (RW), 0x1C STATUS (RW1C).
REQ-018 SHALL use zero wait states: PREADY = 1 whenever PSEL & PENABLE, otherwise 0.
REQ-019 SHALL commit writes on the rising edge where PSEL & PENABLE & PWRITE; register updates SHALL be visible on the next cycle.
REQ-020 SHALL drive PRDATA combinationally during PSEL & PENABLE & !PWRITE, zero-extending above GPIO_W; PRDATA = 0 otherwise, and reads of WO registers SHALL return 0.
REQ-021 SHALL assert PSLVERR together with PREADY for addresses above 0x1C; no state SHALL change on such a write.
REQ-022 SHALL ignore PWDATA bits at GPIO_W and above.
REQ-023 SHALL drive gpio_o = OUT and gpio_oe = DIR directly from registers.
REQ-024 SHALL pass gpio_i through a SYNC_STAGES-flop synchroniser, so IN reflects a pin change SYNC_STAGES cycles later.
REQ-025 SHALL keep a one-cycle-delayed copy of the synchronised input; rise = sync & !prev, fall = !sync & prev.
REQ-026 SHALL set STATUS[n] when (rise[n] & RISE_EN[n]) | (fall[n] & FALL_EN[n]), regardless of DIR[n].
REQ-027 SHALL clear STATUS bits written with 1 and keep bits written with 0.
REQ-028 SHALL let a set event win over a W1C of the same bit in the same cycle.
REQ-029 SHALL drive irq as a registered OR of STATUS, one cycle after STATUS changes.

Reset
REQ-030 SHALL clear on PRESET (synchronous, active-high): OUT, DIR, RISE_EN, FALL_EN, STATUS, the synchroniser and prev flops. Outputs SHALL then be gpio_o = 0, gpio_oe = 0, irq = 0, PRDATA = 0, PREADY = 0, PSLVERR = 0.
REQ-031 SHALL give PRESET priority over a concurrent APB write; a write in a reset cycle is lost.
REQ-032 SHALL NOT produce an edge event on the first cycle after reset, because prev resets together with sync.

Configuration
REQ-033 With macro GPIO_IRQ_EN defined, SHALL include RISE_EN, FALL_EN, STATUS, the edge logic and the irq port.
REQ-034 With GPIO_IRQ_EN undefined, SHALL omit that logic and the irq port; 0x14–0x1C SHALL read 0, ignore writes, and give PSLVERR = 0.

Structure
REQ-035 SHALL place register offsets and the address-width constant in package apb_gpio_pkg.
REQ-036 SHALL implement the synchroniser as sub-module gpio_sync, parameterised by width and depth.

Verification
REQ-037 Reset, then write OUT = 0xA5 and DIR = 0x0F -> gpio_o = 0xA5 and gpio_oe = 0x0F next cycle, and reading 0x00 returns 0x000000A5.
REQ-038 With OUT = 0xA5, write SET = 0x02 then CLR = 0x80 -> OUT = 0x27.
REQ-039 Drive gpio_i from 0x00 to 0x09 -> IN reads 0x00 until SYNC_STAGES cycles elapse, then 0x09.
REQ-040 With RISE_EN = 0x01, pulse gpio_i[0] 0->1 -> STATUS = 0x01 and irq = 1; write 0x01 to STATUS -> irq = 0 two cycles later.
REQ-041 Apply a rising edge on bit 0 in the same cycle as a W1C of STATUS bit 0 -> STATUS[0] remains 1.
REQ-042 Read address 0x40 -> PSLVERR = 1 and PRDATA = 0; write 0x40 -> no register changes.
